// File: rtl/dec_pkg.sv
// Shared decode definitions for the RV32I function decoder and its micro-op queue.
// Optional feature macro: DEC_MEXT_EN (adds the M-extension ALU ops).
package dec_pkg;

   localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
   localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;
   localparam logic [6:0] FUNCT7_MEXT = 7'b0000001;

   localparam logic [2:0] FUNCT3_ADD  = 3'b000;
   localparam logic [2:0] FUNCT3_SLL  = 3'b001;
   localparam logic [2:0] FUNCT3_SLT  = 3'b010;
   localparam logic [2:0] FUNCT3_SLTU = 3'b011;
   localparam logic [2:0] FUNCT3_XOR  = 3'b100;
   localparam logic [2:0] FUNCT3_SR   = 3'b101;
   localparam logic [2:0] FUNCT3_OR   = 3'b110;
   localparam logic [2:0] FUNCT3_AND  = 3'b111;

   localparam logic [2:0] FUNCT3_BEQ  = 3'b000;
   localparam logic [2:0] FUNCT3_BNE  = 3'b001;
   localparam logic [2:0] FUNCT3_BLT  = 3'b100;
   localparam logic [2:0] FUNCT3_BGE  = 3'b101;
   localparam logic [2:0] FUNCT3_BLTU = 3'b110;
   localparam logic [2:0] FUNCT3_BGEU = 3'b111;

   localparam logic [2:0] FUNCT3_LB   = 3'b000;
   localparam logic [2:0] FUNCT3_LH   = 3'b001;
   localparam logic [2:0] FUNCT3_LW   = 3'b010;
   localparam logic [2:0] FUNCT3_LBU  = 3'b100;
   localparam logic [2:0] FUNCT3_LHU  = 3'b101;

   localparam logic [2:0] FUNCT3_SB   = 3'b000;
   localparam logic [2:0] FUNCT3_SH   = 3'b001;
   localparam logic [2:0] FUNCT3_SW   = 3'b010;

   localparam int ALU_ADD  = 0;
   localparam int ALU_SUB  = 1;
   localparam int ALU_AND  = 2;
   localparam int ALU_OR   = 3;
   localparam int ALU_XOR  = 4;
   localparam int ALU_SLL  = 5;
   localparam int ALU_SRL  = 6;
   localparam int ALU_SRA  = 7;
   localparam int ALU_ASG  = 8;
   localparam int ALU_EQ   = 9;
   localparam int ALU_NE   = 10;
   localparam int ALU_LT   = 11;
   localparam int ALU_LTU  = 12;
   localparam int ALU_GT   = 13;
   localparam int ALU_GTU  = 14;
`ifdef DEC_MEXT_EN
   localparam int ALU_MUL  = 15;
   localparam int ALU_REMU = 22;
   localparam int ALU_W    = 23;
`else
   localparam int ALU_W    = 15;
`endif

   // ls = {enable, store, size}; size 11 word / 10 half / 01 byte
   localparam logic [3:0] LS_NONE = 4'b0000;
   localparam logic [3:0] LS_LB   = 4'b1001;
   localparam logic [3:0] LS_LH   = 4'b1010;
   localparam logic [3:0] LS_LW   = 4'b1011;
   localparam logic [3:0] LS_SB   = 4'b1101;
   localparam logic [3:0] LS_SH   = 4'b1110;
   localparam logic [3:0] LS_SW   = 4'b1111;

   typedef struct packed {
      logic [ALU_W-1:0] alu_op;
      logic             rs2_sel;
      logic [3:0]       ls;
      logic             auipc;
      logic             jal;
      logic             jalr;
      logic             branch;
      logic             lsign;
      logic             illegal;
   } uop_t;

   function automatic logic [ALU_W-1:0] alu_bit(input int idx);
      return {{(ALU_W-1){1'b0}}, 1'b1} << idx;
   endfunction

endpackage

// File: rtl/func_decode_comb.sv
// Purely combinational decode of funct fields and opcode class into a micro-op.
// Optional feature macro: DEC_MEXT_EN (OP with funct7 0000001 decodes to MUL..REMU).
module func_decode_comb
   import dec_pkg::*;
(
   input  logic [2:0] funct3,
   input  logic [6:0] funct7,
   input  logic       is_op,
   input  logic       is_op_imm,
   input  logic       is_lui,
   input  logic       is_auipc,
   input  logic       is_jal,
   input  logic       is_jalr,
   input  logic       is_branch,
   input  logic       is_load,
   input  logic       is_store,
   input  logic       is_misc_mem,
   input  logic       is_system,
   output uop_t       uop
);

   // Register/immediate arithmetic mapping shared by OP and OP_IMM; alt picks SUB/SRA.
   function automatic logic [ALU_W-1:0] arith_op(input logic [2:0] f3, input logic alt);
      logic [ALU_W-1:0] op;
      op = '0;
      case (f3)
         FUNCT3_ADD:  op = alu_bit(alt ? ALU_SUB : ALU_ADD);
         FUNCT3_SLL:  op = alu_bit(ALU_SLL);
         FUNCT3_SLT:  op = alu_bit(ALU_LT);
         FUNCT3_SLTU: op = alu_bit(ALU_LTU);
         FUNCT3_XOR:  op = alu_bit(ALU_XOR);
         FUNCT3_SR:   op = alu_bit(alt ? ALU_SRA : ALU_SRL);
         FUNCT3_OR:   op = alu_bit(ALU_OR);
         default:     op = alu_bit(ALU_AND);
      endcase
      return op;
   endfunction

   logic bad;

   // Class-driven decode; illegal encodings keep their class flags but lose alu_op and ls.
   always_comb begin
      uop         = '0;
      uop.rs2_sel = 1'b1;
      bad         = 1'b0;
      if (is_op) begin
         uop.rs2_sel = 1'b0;
         if (funct7 == FUNCT7_BASE)
            uop.alu_op = arith_op(funct3, 1'b0);
         else if (funct7 == FUNCT7_ALT && (funct3 == FUNCT3_ADD || funct3 == FUNCT3_SR))
            uop.alu_op = arith_op(funct3, 1'b1);
`ifdef DEC_MEXT_EN
         else if (funct7 == FUNCT7_MEXT)
            uop.alu_op = alu_bit(ALU_MUL + int'(funct3));
`endif
         else
            bad = 1'b1;
      end else if (is_op_imm) begin
         if (funct3 == FUNCT3_SLL && funct7 != FUNCT7_BASE)
            bad = 1'b1;
         else if (funct3 == FUNCT3_SR && funct7 != FUNCT7_BASE && funct7 != FUNCT7_ALT)
            bad = 1'b1;
         uop.alu_op = arith_op(funct3, funct3 == FUNCT3_SR && funct7[5]);
      end else if (is_lui) begin
         uop.alu_op = alu_bit(ALU_ASG);
      end else if (is_auipc) begin
         uop.alu_op = alu_bit(ALU_ADD);
         uop.auipc  = 1'b1;
      end else if (is_jal) begin
         uop.alu_op = alu_bit(ALU_ADD);
         uop.jal    = 1'b1;
      end else if (is_jalr) begin
         uop.alu_op = alu_bit(ALU_ADD);
         uop.jalr   = 1'b1;
         bad        = (funct3 != 3'b000);
      end else if (is_branch) begin
         uop.rs2_sel = 1'b0;
         uop.branch  = 1'b1;
         case (funct3)
            FUNCT3_BEQ:  uop.alu_op = alu_bit(ALU_EQ);
            FUNCT3_BNE:  uop.alu_op = alu_bit(ALU_NE);
            FUNCT3_BLT:  uop.alu_op = alu_bit(ALU_LT);
            FUNCT3_BGE:  uop.alu_op = alu_bit(ALU_GT);
            FUNCT3_BLTU: uop.alu_op = alu_bit(ALU_LTU);
            FUNCT3_BGEU: uop.alu_op = alu_bit(ALU_GTU);
            default:     bad = 1'b1;
         endcase
      end else if (is_load) begin
         uop.alu_op = alu_bit(ALU_ADD);
         case (funct3)
            FUNCT3_LB:  begin uop.ls = LS_LB; uop.lsign = 1'b1; end
            FUNCT3_LH:  begin uop.ls = LS_LH; uop.lsign = 1'b1; end
            FUNCT3_LW:  uop.ls = LS_LW;
            FUNCT3_LBU: uop.ls = LS_LB;
            FUNCT3_LHU: uop.ls = LS_LH;
            default:    bad = 1'b1;
         endcase
      end else if (is_store) begin
         uop.alu_op = alu_bit(ALU_ADD);
         case (funct3)
            FUNCT3_SB: uop.ls = LS_SB;
            FUNCT3_SH: uop.ls = LS_SH;
            FUNCT3_SW: uop.ls = LS_SW;
            default:   bad = 1'b1;
         endcase
      end else if (is_misc_mem || is_system) begin
         uop.alu_op = '0;
      end else begin
         bad = 1'b1;
      end

      if (bad) begin
         uop.alu_op  = '0;
         uop.ls      = LS_NONE;
         uop.lsign   = 1'b0;
         uop.illegal = 1'b1;
      end
   end

endmodule

// File: rtl/func_decode_q.sv
// Execute-stage function decoder feeding a DEPTH-entry micro-op queue with
// valid/ready on both sides. Optional feature macro: DEC_MEXT_EN.
module func_decode_q
   import dec_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int PC_W  = 32
) (
   input  logic                       CLK,
   input  logic                       RSTN,
   input  logic                       flush,
   input  logic                       inst_vld,
   output logic                       inst_rdy,
   input  logic [2:0]                 funct3_p,
   input  logic [6:0]                 funct7_p,
   input  logic                       is_OP,
   input  logic                       is_OP_IMM,
   input  logic                       is_LUI,
   input  logic                       is_AUIPC,
   input  logic                       is_JAL,
   input  logic                       is_JALR,
   input  logic                       is_BRANCH,
   input  logic                       is_LOAD,
   input  logic                       is_STORE,
   input  logic                       is_MISC_MEM,
   input  logic                       is_SYSTEM,
   input  logic [PC_W-1:0]            inst_pc,
   input  logic                       inst_taken,
   output logic                       uop_vld,
   input  logic                       uop_rdy,
   output logic [ALU_W-1:0]           uop_alu_op,
   output logic                       uop_rs2_sel,
   output logic [3:0]                 uop_ls,
   output logic                       uop_auipc,
   output logic                       uop_jal,
   output logic                       uop_jalr,
   output logic                       uop_branch,
   output logic                       uop_lsign,
   output logic                       uop_illegal,
   output logic [PC_W-1:0]            uop_pc,
   output logic                       uop_taken,
   output logic [$clog2(DEPTH+1)-1:0] q_count
);

   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   uop_t             dec_uop;
   uop_t             q_uop   [DEPTH];
   logic [PC_W-1:0]  q_pc    [DEPTH];
   logic             q_taken [DEPTH];
   logic [PTR_W-1:0] head;
   logic [PTR_W-1:0] tail;
   logic [CNT_W-1:0] count;
   logic             push;
   logic             pop;
   uop_t             head_uop;

   func_decode_comb u_dec (
      .funct3      (funct3_p),
      .funct7      (funct7_p),
      .is_op       (is_OP),
      .is_op_imm   (is_OP_IMM),
      .is_lui      (is_LUI),
      .is_auipc    (is_AUIPC),
      .is_jal      (is_JAL),
      .is_jalr     (is_JALR),
      .is_branch   (is_BRANCH),
      .is_load     (is_LOAD),
      .is_store    (is_STORE),
      .is_misc_mem (is_MISC_MEM),
      .is_system   (is_SYSTEM),
      .uop         (dec_uop)
   );

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // Ready comes from the registered count only, so a pop never opens a full queue in the same cycle.
   assign inst_rdy = (count < CNT_W'(DEPTH));
   assign uop_vld  = (count != '0);
   assign push     = inst_vld & inst_rdy & ~flush;
   assign pop      = uop_vld & uop_rdy & ~flush;
   assign q_count  = count;

   // Pointer and occupancy tracking; flush overrides any push or pop.
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else if (flush) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (push) tail <= next_ptr(tail);
         if (pop)  head <= next_ptr(head);
         if (push && !pop)
            count <= count + 1'b1;
         else if (pop && !push)
            count <= count - 1'b1;
      end
   end

   // Entry storage; stale contents are never visible because outputs are masked by count.
   always_ff @(posedge CLK) begin
      if (push) begin
         q_uop[tail]   <= dec_uop;
         q_pc[tail]    <= inst_pc;
         q_taken[tail] <= inst_taken;
      end
   end

   // Head presentation, forced to zero whenever the queue is empty.
   always_comb begin
      head_uop    = uop_vld ? q_uop[head] : '0;
      uop_alu_op  = head_uop.alu_op;
      uop_rs2_sel = head_uop.rs2_sel;
      uop_ls      = head_uop.ls;
      uop_auipc   = head_uop.auipc;
      uop_jal     = head_uop.jal;
      uop_jalr    = head_uop.jalr;
      uop_branch  = head_uop.branch;
      uop_lsign   = head_uop.lsign;
      uop_illegal = head_uop.illegal;
      uop_pc      = uop_vld ? q_pc[head] : '0;
      uop_taken   = uop_vld ? q_taken[head] : 1'b0;
   end

endmodule
